// File: rtl/ram_port_arbiter_pkg.sv
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and helpers for the block-RAM data-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    // Cycles from request acceptance to the response pulse.
    localparam int RSP_LATENCY = 1;

    typedef logic [3:0] wstrb_t;

    function automatic logic is_read(input wstrb_t wstrb);
        return (wstrb == 4'b0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : Requester bus and RAM data-port bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 8
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*4-1:0]  req_wstrb;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_rdata;
    logic [AW-1:0]      ram_addr;
    wstrb_t             ram_wen;
    logic               ram_ren;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;

    // Arbiter side.
    modport slave (
        input  req_valid, req_wstrb, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_addr, ram_wen, ram_ren, ram_wdata
    );

    // Requesters plus the RAM data port.
    modport master (
        output req_valid, req_wstrb, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_addr, ram_wen, ram_ren, ram_wdata
    );

endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; search starts after `last`.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic          w_found;
        logic [IW-1:0] w_idx;
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // off == N wraps back to `last` itself, so a lone requester can win again.
        for (int off = 1; off <= N; off++) begin
            w_idx = IW'((int'(last) + off) % N);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Round-robin sharing of the block-RAM data port among requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int NREQ  = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus
);

    localparam int c_IW = $clog2(NREQ);

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic [c_IW-1:0] w_gnt_idx;
    logic            w_any;
    wstrb_t          w_sel_wstrb;
    logic [AW-1:0]   w_sel_addr;
    logic [31:0]     w_sel_wdata;

    logic [c_IW-1:0] r_last_grant;
    logic [NREQ-1:0] r_rsp_owner;
    logic            r_rsp_valid;
    logic            r_rsp_is_read;

    // Masking the requests keeps grants, and hence RAM enables, off during reset.
    assign w_req = rst_n ? bus.req_valid : '0;

    rr_arbiter #(
        .N  (NREQ),
        .IW (c_IW)
    ) u_rr (
        .req     (w_req),
        .last    (r_last_grant),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_any         = |w_gnt;
    assign bus.req_ready = w_gnt;

    always_comb begin
        w_sel_wstrb = bus.req_wstrb[int'(w_gnt_idx) * 4  +: 4];
        w_sel_addr  = bus.req_addr [int'(w_gnt_idx) * AW +: AW];
        w_sel_wdata = bus.req_wdata[int'(w_gnt_idx) * 32 +: 32];
    end

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_wen   = '0;
        bus.ram_ren   = 1'b0;
        if (w_any) begin
            bus.ram_addr  = w_sel_addr;
            bus.ram_wdata = w_sel_wdata;
            bus.ram_wen   = w_sel_wstrb;
            bus.ram_ren   = is_read(w_sel_wstrb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= c_IW'(NREQ - 1);
            r_rsp_owner   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_is_read <= 1'b0;
        end else begin
            r_rsp_owner   <= w_gnt;
            r_rsp_valid   <= w_any;
            r_rsp_is_read <= w_any && is_read(w_sel_wstrb);
            if (w_any) begin
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    // RAM read data is already registered, so it lines up with the response cycle.
    assign bus.rsp_valid = r_rsp_valid ? r_rsp_owner : '0;
    assign bus.rsp_rdata = r_rsp_is_read ? bus.ram_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed scoreboard bench for ram_port_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int DEPTH = 256;
    localparam int NREQ  = 2;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [NREQ-1:0] owner;
        logic [31:0]     rdata;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ram_init;

    logic [NREQ-1:0]    tb_valid;
    logic [NREQ*4-1:0]  tb_wstrb;
    logic [NREQ*AW-1:0] tb_addr;
    logic [NREQ*32-1:0] tb_wdata;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ram_q;

    exp_t q[$];
    int   n_eval;
    int   n_fail;

    ram_port_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    ram_port_arbiter #(
        .DEPTH (DEPTH),
        .NREQ  (NREQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.req_valid = tb_valid;
    assign bus.req_wstrb = tb_wstrb;
    assign bus.req_addr  = tb_addr;
    assign bus.req_wdata = tb_wdata;
    assign bus.ram_rdata = ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        if (i == 3)  return 32'h11223344;
        return 32'h5A000000 ^ (32'(i) * 32'h00010101);
    endfunction

    // Block RAM data port: registered read, byte-enabled write.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.ram_ren) ram_q <= mem[bus.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus.ram_wen[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] s,
                           input logic [AW-1:0] a, input logic [31:0] d);
        tb_valid[i]           = v;
        tb_wstrb[i*4 +: 4]    = s;
        tb_addr[i*AW +: AW]   = a;
        tb_wdata[i*32 +: 32]  = d;
    endtask

    // Checks the combinational grant and RAM drive, then queues the expected response.
    task automatic drive_check(input int g);
        logic [NREQ-1:0] exp_gnt;
        logic [3:0]      s;
        logic [AW-1:0]   a;
        logic [31:0]     d;
        exp_t            e;
        #2;
        exp_gnt = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_gnt));
        if (g >= 0) begin
            s = tb_wstrb[g*4 +: 4];
            a = tb_addr[g*AW +: AW];
            d = tb_wdata[g*32 +: 32];
            chk("ram_addr",  32'(bus.ram_addr), 32'(a));
            chk("ram_wen",   32'(bus.ram_wen),  32'(s));
            chk("ram_ren",   32'(bus.ram_ren),  32'(s == 4'h0));
            chk("ram_wdata", bus.ram_wdata,     d);
            e.owner = exp_gnt;
            e.rdata = (s == 4'h0) ? ref_mem[a] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            chk("idle_wen",   32'(bus.ram_wen),  32'h0);
            chk("idle_ren",   32'(bus.ram_ren),  32'h0);
            chk("idle_addr",  32'(bus.ram_addr), 32'h0);
            chk("idle_wdata", bus.ram_wdata,     32'h0);
            e.owner = '0;
            e.rdata = 32'h0;
        end
        q.push_back(e);
    endtask

    task automatic edge_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_eval++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = q.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.owner));
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'h0, '0, 32'h0);
    endtask

    initial begin
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        n_eval   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ram_init = 1'b1;
        tb_valid = '0;
        tb_wstrb = '0;
        tb_addr  = '0;
        tb_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        // Reset state, with requests present that must not be accepted.
        @(posedge clk);
        #1;
        ram_init = 1'b0;
        set_req(0, 1'b1, 4'h0, 8'h10, 32'h0);
        set_req(1, 1'b1, 4'h0, 8'h20, 32'h0);
        #1;
        chk("rst_ready",     32'(bus.req_ready), 32'h0);
        chk("rst_ren",       32'(bus.ram_ren),   32'h0);
        chk("rst_wen",       32'(bus.ram_wen),   32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
        @(posedge clk);
        #1;
        chk("rst_ready_hold", 32'(bus.req_ready), 32'h0);
        clear_reqs();
        rst_n = 1'b1;

        // Single read.
        set_req(0, 1'b1, 4'h0, 8'h10, 32'h0);
        drive_check(0);
        edge_check();
        chk("t1_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        clear_reqs();

        // Byte write then read-after-write.
        set_req(1, 1'b1, 4'b0010, 8'h03, 32'h0000AB00);
        drive_check(1);
        edge_check();
        set_req(1, 1'b1, 4'h0, 8'h03, 32'h0);
        drive_check(1);
        edge_check();
        chk("t2_rdata", bus.rsp_rdata, 32'h1122AB44);
        clear_reqs();

        // Full-word write racing a read of the same word.
        set_req(0, 1'b1, 4'hF, 8'h05, 32'hCAFEF00D);
        set_req(1, 1'b1, 4'h0, 8'h05, 32'h0);
        drive_check(0);
        edge_check();
        set_req(0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_check(1);
        edge_check();
        chk("t3_rdata", bus.rsp_rdata, 32'hCAFEF00D);
        clear_reqs();

        // Contention right after reset: strict alternation.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        a0 = 8'h20;
        a1 = 8'h40;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 4'h0, a0, 32'h0);
            set_req(1, 1'b1, 4'h0, a1, 32'h0);
            drive_check(k % 2);
            edge_check();
            if (k % 2 == 0) a0 = a0 + 8'd1;
            else            a1 = a1 + 8'd1;
        end
        clear_reqs();

        // Back-to-back reads from a single requester.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 4'h0, AW'(k), 32'h0);
            drive_check(0);
            edge_check();
        end
        chk("b2b_last", bus.rsp_rdata, ref_mem[3]);
        clear_reqs();

        // Idle: stale addresses on the inputs must not leak out.
        set_req(0, 1'b0, 4'hF, 8'h77, 32'h12345678);
        for (int k = 0; k < 10; k++) begin
            drive_check(-1);
            edge_check();
        end
        clear_reqs();

        // Reset mid-flight after a read grant to requester 0.
        set_req(1, 1'b1, 4'h0, 8'h10, 32'h0);
        drive_check(1);
        edge_check();
        set_req(1, 1'b0, 4'h0, 8'h00, 32'h0);
        set_req(0, 1'b1, 4'h0, 8'h11, 32'h0);
        drive_check(0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(q.pop_front());
        #1;
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rsp_rdata", bus.rsp_rdata,      32'h0);
        set_req(1, 1'b1, 4'h0, 8'h20, 32'h0);
        #1;
        chk("mid_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_check(0);
        edge_check();
        set_req(0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_check(1);
        edge_check();
        clear_reqs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single data port of the SoC block RAM between `NREQ` requesters, such as the core load/store unit, a DMA engine and a debug/boot loader. Each cycle it grants at most one valid request using round-robin priority and drives the RAM's data-side address, byte-write-enable, read-enable and write-data inputs. It routes the RAM's registered read data back to the winning requester with a one-cycle response pulse. It sits between the requester bus fabric and the RAM's data port. The instruction port is not touched.

## Interface
Parameters:
- `DEPTH`, 256: RAM depth in 32-bit words. Must be a power of two and ≥ 2.
- `NREQ`, 2: number of requesters. Legal range is 2..8.
- `AW`, `$clog2(DEPTH)`: word-address width. Derived; never overridden.

Ports:
- `clk`, in, 1: single clock, shared with the RAM data-port clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, `NREQ`: request valid, one bit per requester.
- `req_wstrb`, in, `NREQ*4`: byte write strobes per requester. All-zero means read; any nonzero value means write.
- `req_addr`, in, `NREQ*AW`: word address per requester.
- `req_wdata`, in, `NREQ*32`: write data per requester.
- `req_ready`, out, `NREQ`: request accepted this cycle (one-hot or zero).
- `rsp_valid`, out, `NREQ`: one-hot response pulse, one cycle after acceptance.
- `rsp_rdata`, out, 32: read data. Valid only when `rsp_valid` is set for a read.
- `ram_addr`, out, `AW`: to the RAM data-port address.
- `ram_wen`, out, 4: to the RAM data-port byte write enables.
- `ram_ren`, out, 1: to the RAM data-port read enable.
- `ram_wdata`, out, 32: to the RAM data-port write data.
- `ram_rdata`, in, 32: from the RAM data-port registered read output.

## Operation
- Arbitration is round-robin over `req_valid`. The search starts at `last_grant+1` modulo `NREQ`, and the first asserted requester wins.
- `last_grant` updates only on an accepted request. Reset value is `NREQ-1`, so requester 0 wins first after reset.
- `req_ready[i] = grant[i]`. Grant is combinational from `req_valid` and `last_grant`. A request is accepted when `req_valid[i] && req_ready[i]`.
- A requester holds its valid, address, strobes and data stable until accepted.
- RAM drive for the granted requester:
  - `ram_addr`, `ram_wdata` and `ram_wen` come from the winner's `req_addr`, `req_wdata` and `req_wstrb`.
  - `ram_ren` is 1 only when the winner's `req_wstrb` is 0.
- With no grant: `ram_wen=0`, `ram_ren=0`, and `ram_addr`/`ram_wdata` hold 0 (no X leakage).
- Read and write are mutually exclusive per request. A write never produces a read.
- Response tracking uses two registers:
  - `rsp_owner`, one-hot `NREQ`, and `rsp_valid`. Both are loaded at the acceptance edge.
  - Every accepted request, read or write, produces exactly one `rsp_valid` pulse to its owner in the next cycle. For writes this pulse is the write acknowledge.
- `rsp_rdata` is a pass-through of `ram_rdata`, gated to 0 when no read response is pending.
- There is no response backpressure. Requesters must sink `rsp_valid` unconditionally.
- Throughput is one request per cycle. Back-to-back grants, including to the same requester when it is the only one active, are allowed.
- A request is never accepted while `rst_n` is low.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `rsp_valid=0`, `rsp_owner=0`, `last_grant=NREQ-1`.
  - `req_ready=0`, `ram_wen=0`, `ram_ren=0` (forced while in reset).
- Request accepted in cycle N. The RAM samples address, enables and data at the end-of-N edge.
- Cycle N+1: `rsp_valid[owner]=1`. For a read, `rsp_rdata` holds the RAM word.
- Read-after-write to the same address in cycles N and N+1 returns the new data, because the RAM write completes at the end-of-N edge.
- Simultaneous requests from all requesters are serviced in strict rotation. Worst-case wait is `NREQ-1` cycles.
- A requester dropping `req_valid` before acceptance is legal. It loses its slot with no side effects.
- Reset asserted mid-transaction discards a pending response. The RAM contents write at that edge is undefined, and the bench does not check it.

## Structure
- Shared package `ram_arb_pkg` holds:
  - `RSP_LATENCY = 1`.
  - `typedef logic [3:0] wstrb_t`.
  - A helper function `is_read(wstrb_t)`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]` and `last[$clog2(N)]`.
  - Outputs: one-hot `gnt[N]` and its encoded index.
  - Purely combinational. `ram_port_arbiter` owns the `last_grant` register.
- Top-level contents:
  - Request mux by grant index.
  - RAM output gating.
  - `rsp_owner`/`rsp_is_read` registers.
  - Response routing.

## Test plan
- Single read: requester 0 reads address 0x10, RAM preloaded with 0xDEADBEEF there. Expect `req_ready[0]` in the same cycle, then `rsp_valid=2'b01` and `rsp_rdata=0xDEADBEEF` in the next cycle.
- Byte write then read: requester 1 writes wstrb 4'b0010 with data 0x0000AB00 to address 3, which initially holds 0x11223344. Requester 1 then reads address 3. Expect a write ack pulse, then read data 0x1122AB44.
- Contention: both requesters keep a read pending for 6 cycles after reset. Expect grants in the order 0,1,0,1,0,1, each response one cycle after its grant, and no cycle with both ready bits set.
- Back-to-back single requester: requester 0 issues 4 consecutive reads of addresses 0..3. Expect 4 grants in 4 cycles and responses in cycles 1..4 carrying mem[0..3] in order.
- Reset mid-flight: assert `rst_n` low in the cycle after a read grant. Expect `rsp_valid=0` immediately. After release, requester 0 wins first even if requester 1 was last granted.
- Idle: no `req_valid` for 10 cycles. Expect `ram_wen=0`, `ram_ren=0`, `rsp_valid=0` and `rsp_rdata=0` throughout.
